counter_arbiter: RTL
====================

# counter_arbiter

Round-robin scheduler that shares one up-counter between N requesters. Each requester asks for a timed interval of programmable length. The block grants one requester at a time, runs the shared counter from 0 up to that requester's length, then pulses a per-requester done. It sits between client logic needing timed waits and a single counter resource, so each client does not need its own counter.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 4: counter and length width in bits.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; active-low, asynchronous.
- req  in  N  per-requester request level. Must be held until done, or dropped to abort.
- len  in  N*WIDTH  job lengths; requester i uses bits [i*WIDTH +: WIDTH]. Sampled only at grant.
- gnt  out  N  one-hot grant, held for the entire job (RUN and DONE states).
- done  out  N  one-cycle completion pulse to the granted requester.
- busy  out  1  high in RUN and DONE.
- count  out  WIDTH  current value of the shared counter.

## Operation
- Reset (rst=0) acts immediately, independent of clk:
  - state=IDLE; gnt=0, done=0, busy=0, count=0.
  - Internal last-grant pointer set to N-1, so requester 0 has first priority.
  - No done pulse is issued for a job interrupted by reset.
- IDLE:
  - If any req bit is set, choose i as the first set bit searching from (last+1) mod N upward, with wrap.
  - Next cycle: gnt[i]=1, count=0, captured target=len[i], last=i, state=RUN.
  - If req=0, remain in IDLE.
- RUN:
  - If req[i]=0 at the clock edge, abort: next cycle is IDLE with gnt=0, count=0, and no done.
  - Otherwise, if count==target, go to DONE and hold count.
  - Otherwise, count increments by 1.
  - Abort has priority over completion on the same edge.
- DONE:
  - Lasts one cycle: done[i]=1, gnt[i]=1, count=target.
  - The next state is always IDLE with gnt=0 and count=0.
  - req[i] is ignored in this state; the done pulse is issued regardless.
- Arithmetic:
  - count never wraps, because target ≤ 2^WIDTH−1 and counting stops at target.
  - len=0 is legal and gives a one-cycle RUN.
- The captured target is frozen for the job; changes to len during RUN are ignored.
- Requests that arrive or drop while the block is busy, for non-granted indices, have no effect until the next IDLE.

## Timing
- Edge T, IDLE with req[i]=1:
  - gnt[i]=1, busy=1, count=0 from T+1.
  - count=k at T+1+k for k ≤ len.
  - done[i]=1 at T+2+len.
  - IDLE with gnt=0 at T+3+len.
- Request-to-done latency: len+2 cycles.
- Back-to-back jobs: at least one IDLE cycle between consecutive grants.
  - The grant period is len+3 cycles when requests are continuously pending.
- gnt is never multi-hot. done is never high outside DONE. done is a subset of gnt.
- All outputs are registered; there are no combinational paths from req or len to any output.

## Test plan
- Reset:
  - Stimulus: assert rst=0 between clock edges.
  - Required: gnt, done, busy, count go to 0 without waiting for clk.
  - After release with req=0, the block stays IDLE for 10 cycles.
- Single job:
  - Stimulus: req=0001, len0=3, sampled at T.
  - Required: gnt=0001 from T+1; count=0,1,2,3 on T+1..T+4; done=0001 only at T+5; gnt=0 and busy=0 at T+6.
- Round-robin:
  - Stimulus: req=1111 held, all len=0.
  - Required: grant order 0,1,2,3,0,1, each grant spaced 3 cycles apart; exactly one done per grant.
- Full range:
  - Stimulus: WIDTH=4, len=15.
  - Required: count reaches 15 and holds there, with no wrap to 0 during RUN; done at T+17.
- Abort:
  - Stimulus: req[2] dropped at the edge where count=2 (len2=5); req[3] also pending.
  - Required: next cycle gnt=0, count=0, no done[2]; the next grant goes to requester 3.
  - Abort-vs-completion: drop req at the edge where count==target; no done is issued.
- Reset mid-job:
  - Stimulus: rst=0 while count=2 on a grant to requester 1.
  - Required: immediate clear, no done.
  - After release with req=0011, the first grant goes to requester 0 (pointer reset).

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up-counter among N requesters.
// Each granted job counts from 0 to its captured length, then pulses done.
module counter_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] len_i,
  output logic [N-1:0]       gnt_o,
  output logic [N-1:0]       done_o,
  output logic               busy_o,
  output logic [WIDTH-1:0]   count_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [IW-1:0]    last_q, last_d;

  logic [IW-1:0]    pick;
  logic             found;
  int               cand;

  // Search upward from the slot after the last grant, wrapping, so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_q) + k) % N;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    count_d  = count_q;
    target_d = target_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = RUN;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          count_d     = '0;
          target_d    = len_i[pick*WIDTH +: WIDTH];
          last_d      = pick;
        end
      end
      RUN: begin
        // A dropped request wins over completion on the same edge.
        if ((req_i & gnt_q) == '0) begin
          state_d = IDLE;
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q == target_q) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      count_q  <= '0;
      target_q <= '0;
      last_q   <= IW'(N - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      count_q  <= count_d;
      target_q <= target_d;
      last_q   <= last_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != IDLE);

endmodule
